// File: rtl/phase_sequencer.sv
// phase_sequencer: steps a PLL phase table on synchronized trigger/change-phase edges, with abort and run timeout.
module phase_sequencer #(
  parameter int TABLE_DEPTH = 32,
  parameter int PHASE_W = 5,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW = $clog2(TABLE_DEPTH),
  localparam int SW = AW + 1,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_arm,
  input  logic               cmd_abort,
  input  logic               trigger_in,
  input  logic               change_phase_in,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic [AW:0]        num_steps,
  output logic [PHASE_W-1:0] phase_out,
  output logic               output_on,
  output logic               armed,
  output logic [1:0]         state,
  output logic [AW-1:0]      step_idx,
  output logic               change_phase_out,
  output logic               timeout_flag
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
  state_t             r_state, w_state_nx;
  logic [2:0]         r_trg_sync, r_chg_sync;
  logic [PHASE_W-1:0] r_table [TABLE_DEPTH];
  logic [PHASE_W-1:0] r_phase, w_phase_nx;
  logic [AW-1:0]      r_step, w_step_nx, w_step_inc;
  logic [SW-1:0]      r_steps, w_steps_nx, w_steps_clamped;
  logic [CW-1:0]      r_cnt, w_cnt_nx;
  logic               r_on, w_on_nx, r_cp, w_cp_nx, r_tof, w_tof_nx;
  logic               w_trg_edge, w_chg_edge, w_last, w_timeout;
  assign w_trg_edge = r_trg_sync[1] & ~r_trg_sync[2];
  assign w_chg_edge = r_chg_sync[1] & ~r_chg_sync[2];
  assign w_step_inc = r_step + AW'(1);
  assign w_last = ({1'b0, r_step} == r_steps - SW'(1));
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_steps_clamped = (num_steps == '0) ? SW'(1) :
                           (num_steps > SW'(TABLE_DEPTH)) ? SW'(TABLE_DEPTH) : num_steps;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trg_sync <= '0;
      r_chg_sync <= '0;
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_step     <= '0;
      r_steps    <= SW'(1);
      r_cnt      <= '0;
      r_on       <= 1'b0;
      r_cp       <= 1'b0;
      r_tof      <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++) r_table[i] <= '0;
    end else begin
      r_trg_sync <= {r_trg_sync[1:0], trigger_in};
      r_chg_sync <= {r_chg_sync[1:0], change_phase_in};
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_step     <= w_step_nx;
      r_steps    <= w_steps_nx;
      r_cnt      <= w_cnt_nx;
      r_on       <= w_on_nx;
      r_cp       <= w_cp_nx;
      r_tof      <= w_tof_nx;
      if (cfg_we && r_state != S_RUN) r_table[cfg_addr] <= cfg_data;
    end
  end
  // abort overrides everything; in RUNNING a change-phase edge beats a same-cycle timeout
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_step_nx  = r_step;
    w_steps_nx = r_steps;
    w_cnt_nx   = r_cnt;
    w_on_nx    = r_on;
    w_cp_nx    = 1'b0;
    w_tof_nx   = r_tof;
    if (cmd_abort) begin
      w_state_nx = S_IDLE;
      w_phase_nx = '0;
      w_step_nx  = '0;
      w_cnt_nx   = '0;
      w_on_nx    = 1'b0;
      w_tof_nx   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (cmd_arm) begin
          w_state_nx = S_ARMED;
          w_steps_nx = w_steps_clamped;
          w_step_nx  = '0;
          w_tof_nx   = 1'b0;
        end
        S_ARMED: if (w_trg_edge) begin
          w_state_nx = S_RUN;
          w_step_nx  = '0;
          w_phase_nx = r_table[0];
          w_on_nx    = 1'b1;
          w_cnt_nx   = '0;
        end
        S_RUN: if (w_chg_edge) begin
          w_cp_nx    = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = w_last ? S_DONE : S_RUN;
          w_on_nx    = ~w_last;
          w_step_nx  = w_last ? r_step : w_step_inc;
          w_phase_nx = w_last ? r_phase : r_table[w_step_inc];
        end else if (w_timeout) begin
          w_state_nx = S_DONE;
          w_on_nx    = 1'b0;
          w_tof_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      endcase
    end
  end
  assign phase_out        = r_phase;
  assign output_on        = r_on;
  assign armed            = (r_state == S_ARMED);
  assign state            = r_state;
  assign step_idx         = r_step;
  assign change_phase_out = r_cp;
  assign timeout_flag     = r_tof;
endmodule
